// File: rtl/pic_pkg.sv
// pic_pkg
// Shared definitions for the PIC interrupt stage: OCW2 command codes,
// the INTA acknowledge FSM state type and the rotating-priority helpers.
// No ports; imported by pic_prio_resolver and pic_irq_ctrl.
package pic_pkg;

    // OCW2 command field, bits {R, SL, EOI}
    localparam logic [2:0] OCW2_NSEOI     = 3'b001;
    localparam logic [2:0] OCW2_SEOI      = 3'b011;
    localparam logic [2:0] OCW2_ROT_NSEOI = 3'b101;
    localparam logic [2:0] OCW2_ROT_SEOI  = 3'b111;
    localparam logic [2:0] OCW2_SET_PRIO  = 3'b110;

    // Level reported when INTA arrives with nothing pending
    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2
    } pic_state_e;

    // Returns {valid, level} of the highest-priority set bit of mask,
    // where base is the highest-priority level and the order wraps 7->0.
    // The loop walks from lowest to highest priority so the last hit wins.
    function automatic logic [3:0] highestPrio(input logic [7:0] mask,
                                               input logic [2:0] base);
        logic [3:0] result;
        logic [2:0] idx;
        result = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (mask[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    // Position of a level in the rotating order; 0 is highest priority.
    function automatic logic [2:0] rankOf(input logic [2:0] lvl,
                                          input logic [2:0] base);
        return lvl - base;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// pic_prio_resolver
// Combinational rotating find-first over an 8-bit request mask.
// Ports:
//   mask_i      8  requests, bit i = level i
//   prioBase_i  3  level currently holding highest priority
//   valid_o     1  at least one bit of mask_i is set
//   lvl_o       3  highest-priority set level (0 when valid_o = 0)
module pic_prio_resolver
    import pic_pkg::*;
(
    input  logic [7:0] mask_i,
    input  logic [2:0] prioBase_i,
    output logic       valid_o,
    output logic [2:0] lvl_o
);

    always_comb begin
        {valid_o, lvl_o} = highestPrio(mask_i, prioBase_i);
    end

endmodule

// File: rtl/pic_irq_ctrl.sv
// pic_irq_ctrl
// Request latching, priority resolution and INTA acknowledge stage of an
// 8259-style PIC.
// Ports:
//   clk_i         1  system clock
//   rstn_i        1  asynchronous active-low reset
//   ir_i          8  raw interrupt request lines
//   icw1_ltim_i   1  1 = level-triggered, 0 = edge-triggered
//   icw2_vec_i    5  vector base T7..T3
//   icw4_aeoi_i   1  automatic EOI enable
//   ocw1_imr_i    8  interrupt mask, 1 masks the level
//   ocw2_i        8  OCW2 byte {R,SL,EOI,0,0,L2..L0}
//   ocw2_wr_i     1  single-cycle OCW2 write strobe
//   ocw3_ris_i    1  status select, 0 = IRR, 1 = ISR
//   intan_i       1  INTA from CPU, active-low, synchronous
//   int_o         1  interrupt request to CPU
//   vec_o         8  interrupt vector
//   vec_oe_o      1  vector valid / bus drive enable
//   stat_o        8  registered IRR or ISR
module pic_irq_ctrl
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] ir_i,
    input  logic       icw1_ltim_i,
    input  logic [4:0] icw2_vec_i,
    input  logic       icw4_aeoi_i,
    input  logic [7:0] ocw1_imr_i,
    input  logic [7:0] ocw2_i,
    input  logic       ocw2_wr_i,
    input  logic       ocw3_ris_i,
    input  logic       intan_i,
    output logic       int_o,
    output logic [7:0] vec_o,
    output logic       vec_oe_o,
    output logic [7:0] stat_o
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] irPrev_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] prioBase_q, prioBase_d;
    logic       intanDly_q;
    pic_state_e state_q, state_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spurious_q, spurious_d;
    logic       int_q, int_d;
    logic [7:0] vec_q, vec_d;
    logic       vecOe_q, vecOe_d;
    logic [7:0] stat_q;

    logic [7:0] irSync;
    logic [7:0] irRise;
    logic       intanFall, intanRise;
    logic       candValid, isrValid;
    logic [2:0] candLvl, isrLvl;
    logic       ackTake;
    logic       aeoiClear;
    logic       ocw2Valid;
    logic [2:0] ocw2Lvl;

    assign irSync    = sync_q[SYNC_STAGES-1];
    assign irRise    = irSync & ~irPrev_q;
    assign intanFall = intanDly_q & ~intan_i;
    assign intanRise = ~intanDly_q & intan_i;
    // D4..D3 = 00 distinguishes an OCW2 byte from OCW3
    assign ocw2Valid = ocw2_wr_i && (ocw2_i[4:3] == 2'b00);
    assign ocw2Lvl   = ocw2_i[2:0];

    pic_prio_resolver u_candResolver (
        .mask_i     (irr_q & ~ocw1_imr_i),
        .prioBase_i (prioBase_q),
        .valid_o    (candValid),
        .lvl_o      (candLvl)
    );

    pic_prio_resolver u_isrResolver (
        .mask_i     (isr_q),
        .prioBase_i (prioBase_q),
        .valid_o    (isrValid),
        .lvl_o      (isrLvl)
    );

    assign ackTake   = (state_q == IDLE) && intanFall && candValid;
    assign aeoiClear = (state_q == ACK2) && intanRise && icw4_aeoi_i && !spurious_q;

    // Input synchronizers plus the delayed copies used for edge detection
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            irPrev_q   <= '0;
            intanDly_q <= 1'b1;
        end else begin
            sync_q[0] <= ir_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            irPrev_q   <= irSync;
            intanDly_q <= intan_i;
        end
    end

    // IRR: edge mode holds a captured rise only while the line stays high;
    // the acknowledge clear is applied last so it wins over a same-cycle set
    always_comb begin
        irr_d = icw1_ltim_i ? irSync : ((irr_q & irSync) | irRise);
        if (ackTake) begin
            irr_d[candLvl] = 1'b0;
        end
    end

    // ISR and priority base: EOI decisions use the pre-update ISR, then the
    // INTA set is applied so it overrides any clear on the same bit
    always_comb begin
        isr_d      = isr_q;
        prioBase_d = prioBase_q;
        if (ocw2Valid) begin
            case (ocw2_i[7:5])
                OCW2_NSEOI: begin
                    if (isrValid) isr_d[isrLvl] = 1'b0;
                end
                OCW2_SEOI: begin
                    isr_d[ocw2Lvl] = 1'b0;
                end
                OCW2_ROT_NSEOI: begin
                    if (isrValid) begin
                        isr_d[isrLvl] = 1'b0;
                        prioBase_d    = isrLvl + 3'd1;
                    end
                end
                OCW2_ROT_SEOI: begin
                    isr_d[ocw2Lvl] = 1'b0;
                    prioBase_d     = ocw2Lvl + 3'd1;
                end
                OCW2_SET_PRIO: begin
                    prioBase_d = ocw2Lvl + 3'd1;
                end
                default: ;
            endcase
        end
        if (aeoiClear) begin
            isr_d[lvl_q] = 1'b0;
        end
        if (ackTake) begin
            isr_d[candLvl] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: each INTA falling edge advances, the final rise returns
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (intanFall) state_d = ACK1;
            ACK1:    if (intanFall) state_d = ACK2;
            ACK2:    if (intanRise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: level capture, vector drive and the fully nested INT
    // request, which is only raised while no acknowledge is in progress
    always_comb begin
        lvl_d      = lvl_q;
        spurious_d = spurious_q;
        vec_d      = vec_q;
        vecOe_d    = vecOe_q;
        int_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (intanFall) begin
                    lvl_d      = candValid ? candLvl : SPURIOUS_LVL;
                    spurious_d = !candValid;
                end else begin
                    int_d = candValid &&
                            (!isrValid ||
                             (rankOf(candLvl, prioBase_q) < rankOf(isrLvl, prioBase_q)));
                end
            end
            ACK1: begin
                if (intanFall) begin
                    vec_d   = {icw2_vec_i, lvl_q};
                    vecOe_d = 1'b1;
                end
            end
            ACK2: begin
                if (intanRise) begin
                    vec_d   = '0;
                    vecOe_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irr_q      <= '0;
            isr_q      <= '0;
            prioBase_q <= '0;
            lvl_q      <= '0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
            vec_q      <= '0;
            vecOe_q    <= 1'b0;
            stat_q     <= '0;
        end else begin
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            prioBase_q <= prioBase_d;
            lvl_q      <= lvl_d;
            spurious_q <= spurious_d;
            int_q      <= int_d;
            vec_q      <= vec_d;
            vecOe_q    <= vecOe_d;
            stat_q     <= ocw3_ris_i ? isr_q : irr_q;
        end
    end

    assign int_o    = int_q;
    assign vec_o    = vec_q;
    assign vec_oe_o = vecOe_q;
    assign stat_o   = stat_q;

endmodule

// File: tb/tb_pic_irq_ctrl.sv
// tb_pic_irq_ctrl
// Directed self-checking bench for pic_irq_ctrl. Inputs change just after
// the falling clock edge and outputs are sampled on falling edges.
module tb_pic_irq_ctrl;

    logic       clk;
    logic       rstn;
    logic [7:0] ir;
    logic       icw1Ltim;
    logic [4:0] icw2Vec;
    logic       icw4Aeoi;
    logic [7:0] ocw1Imr;
    logic [7:0] ocw2;
    logic       ocw2Wr;
    logic       ocw3Ris;
    logic       intan;
    logic       intReq;
    logic [7:0] vec;
    logic       vecOe;
    logic [7:0] stat;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] vecSeen;
    logic       oeSeen;

    pic_irq_ctrl #(.SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .ir_i        (ir),
        .icw1_ltim_i (icw1Ltim),
        .icw2_vec_i  (icw2Vec),
        .icw4_aeoi_i (icw4Aeoi),
        .ocw1_imr_i  (ocw1Imr),
        .ocw2_i      (ocw2),
        .ocw2_wr_i   (ocw2Wr),
        .ocw3_ris_i  (ocw3Ris),
        .intan_i     (intan),
        .int_o       (intReq),
        .vec_o       (vec),
        .vec_oe_o    (vecOe),
        .stat_o      (stat)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guards against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives request lines and mask together
    task automatic applyStimulus(input logic [7:0] irVal, input logic [7:0] imrVal);
        ir      = irVal;
        ocw1Imr = imrVal;
    endtask

    task automatic writeOcw2(input logic [7:0] value);
        ocw2   = value;
        ocw2Wr = 1'b1;
        waitCycles(1);
        ocw2Wr = 1'b0;
        waitCycles(1);
    endtask

    // Two INTA pulses, each phase three cycles; samples the vector in the
    // second low phase
    task automatic intaSequence(output logic [7:0] vecOut, output logic oeOut);
        intan = 1'b0;
        waitCycles(3);
        intan = 1'b1;
        waitCycles(3);
        intan = 1'b0;
        waitCycles(3);
        vecOut = vec;
        oeOut  = vecOe;
        intan  = 1'b1;
        waitCycles(3);
    endtask

    initial begin
        rstn     = 1'b0;
        ir       = 8'h00;
        icw1Ltim = 1'b0;
        icw2Vec  = 5'b01000;
        icw4Aeoi = 1'b0;
        ocw1Imr  = 8'h00;
        ocw2     = 8'h00;
        ocw2Wr   = 1'b0;
        ocw3Ris  = 1'b1;
        intan    = 1'b1;
        waitCycles(3);
        checkOutput("rst_int", {7'd0, intReq}, 8'h00);
        checkOutput("rst_vec", vec, 8'h00);
        checkOutput("rst_oe", {7'd0, vecOe}, 8'h00);
        checkOutput("rst_stat", stat, 8'h00);
        rstn = 1'b1;
        waitCycles(2);

        // Basic request on IR3 and its acknowledge
        applyStimulus(8'h08, 8'h00);
        waitCycles(3);
        checkOutput("t1_int_early", {7'd0, intReq}, 8'h00);
        waitCycles(1);
        checkOutput("t1_int_rise", {7'd0, intReq}, 8'h01);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t1_vec", vecSeen, 8'h43);
        checkOutput("t1_oe", {7'd0, oeSeen}, 8'h01);
        checkOutput("t1_oe_after", {7'd0, vecOe}, 8'h00);
        checkOutput("t1_isr", stat, 8'h08);
        checkOutput("t1_int_low", {7'd0, intReq}, 8'h00);
        writeOcw2(8'h20);
        waitCycles(1);
        checkOutput("t1_eoi_isr", stat, 8'h00);
        applyStimulus(8'h00, 8'h00);
        waitCycles(5);

        // Masked request, then unmasking
        ocw3Ris = 1'b0;
        applyStimulus(8'h08, 8'h08);
        waitCycles(6);
        checkOutput("t2_int_masked", {7'd0, intReq}, 8'h00);
        checkOutput("t2_irr", stat, 8'h08);
        applyStimulus(8'h08, 8'h00);
        waitCycles(1);
        checkOutput("t2_int_unmask", {7'd0, intReq}, 8'h01);
        applyStimulus(8'h00, 8'h00);
        waitCycles(5);
        checkOutput("t2_int_drop", {7'd0, intReq}, 8'h00);
        checkOutput("t2_irr_clear", stat, 8'h00);
        ocw3Ris = 1'b1;

        // Fully nested: IR5 in service, IR6 blocked, IR2 preempts
        applyStimulus(8'h20, 8'h00);
        waitCycles(5);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t3_vec5", vecSeen, 8'h45);
        checkOutput("t3_isr5", stat, 8'h20);
        applyStimulus(8'h60, 8'h00);
        waitCycles(6);
        checkOutput("t3_int_ir6", {7'd0, intReq}, 8'h00);
        applyStimulus(8'h64, 8'h00);
        waitCycles(5);
        checkOutput("t3_int_ir2", {7'd0, intReq}, 8'h01);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t3_vec2", vecSeen, 8'h42);
        checkOutput("t3_isr", stat, 8'h24);
        applyStimulus(8'h00, 8'h00);
        waitCycles(5);
        writeOcw2(8'h62);
        writeOcw2(8'h65);
        waitCycles(1);
        checkOutput("t3_seoi_isr", stat, 8'h00);

        // Rotate on non-specific EOI moves priority base to 5
        applyStimulus(8'h10, 8'h00);
        waitCycles(5);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t4_vec4", vecSeen, 8'h44);
        applyStimulus(8'h00, 8'h00);
        waitCycles(4);
        checkOutput("t4_isr4", stat, 8'h10);
        writeOcw2(8'hA0);
        waitCycles(1);
        checkOutput("t4_rot_isr", stat, 8'h00);
        applyStimulus(8'h21, 8'h00);
        waitCycles(5);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t4_vec5", vecSeen, 8'h45);
        checkOutput("t4_isr5", stat, 8'h20);
        checkOutput("t4_int_ir0_blocked", {7'd0, intReq}, 8'h00);
        writeOcw2(8'h20);
        waitCycles(1);
        checkOutput("t4_int_ir0", {7'd0, intReq}, 8'h01);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t4_vec0", vecSeen, 8'h40);
        checkOutput("t4_isr0", stat, 8'h01);
        applyStimulus(8'h00, 8'h00);
        writeOcw2(8'h20);
        waitCycles(3);
        checkOutput("t4_isr_clear", stat, 8'h00);

        // Spurious: edge-mode request withdrawn before INTA
        applyStimulus(8'h02, 8'h00);
        waitCycles(5);
        checkOutput("t5_int_on", {7'd0, intReq}, 8'h01);
        applyStimulus(8'h00, 8'h00);
        waitCycles(6);
        checkOutput("t5_int_off", {7'd0, intReq}, 8'h00);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t5_vec7", vecSeen, 8'h47);
        checkOutput("t5_oe", {7'd0, oeSeen}, 8'h01);
        checkOutput("t5_isr", stat, 8'h00);

        // Automatic EOI
        icw4Aeoi = 1'b1;
        applyStimulus(8'h10, 8'h00);
        waitCycles(5);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t6_vec4", vecSeen, 8'h44);
        checkOutput("t6_aeoi_isr", stat, 8'h00);

        // Reset between the two INTA pulses
        applyStimulus(8'h00, 8'h00);
        waitCycles(4);
        applyStimulus(8'h10, 8'h00);
        waitCycles(5);
        checkOutput("t6_int_again", {7'd0, intReq}, 8'h01);
        intan = 1'b0;
        waitCycles(3);
        intan = 1'b1;
        waitCycles(3);
        checkOutput("t6_isr_ack1", stat, 8'h10);
        intan = 1'b0;
        waitCycles(3);
        checkOutput("t6_oe_before_rst", {7'd0, vecOe}, 8'h01);
        rstn = 1'b0;
        #1;
        checkOutput("t6_oe_async", {7'd0, vecOe}, 8'h00);
        checkOutput("t6_int_rst", {7'd0, intReq}, 8'h00);
        checkOutput("t6_stat_rst", stat, 8'h00);
        checkOutput("t6_vec_rst", vec, 8'h00);
        waitCycles(2);
        intan = 1'b1;
        rstn  = 1'b1;
        waitCycles(5);
        checkOutput("t6_int_post_rst", {7'd0, intReq}, 8'h01);
        intaSequence(vecSeen, oeSeen);
        checkOutput("t6_vec_post_rst", vecSeen, 8'h44);
        checkOutput("t6_oe_post_rst", {7'd0, oeSeen}, 8'h01);
        checkOutput("t6_isr_post_rst", stat, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pic_irq_ctrl.md
# pic_irq_ctrl

Interrupt-request, priority-resolution and acknowledge stage of the 8259-style PIC. It sits directly downstream of the read/write control logic and consumes the ICW/OCW register contents and the OCW2 write strobe from that block. It latches IR requests, resolves priority, and drives INT to the CPU. It then runs the two-pulse INTA sequence and produces the interrupt vector for the data bus buffer.

## Interface
- SYNC_STAGES, 2, synchronizer flops on each raw `ir` line (≥2)
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- ir  in  8  raw interrupt requests; bit i = IRi
- icw1_ltim  in  1  1 = level-triggered, 0 = edge-triggered
- icw2_vec  in  5  vector base T7..T3
- icw4_aeoi  in  1  automatic EOI enable
- ocw1_imr  in  8  mask; bit i = 1 masks IRi
- ocw2  in  8  OCW2 byte {R,SL,EOI,0,0,L2..L0}
- ocw2_wr  in  1  one-cycle strobe, ocw2 valid
- ocw3_ris  in  1  status select: 0 = IRR, 1 = ISR
- intan  in  1  INTA from CPU, active-low, synchronous to clk
- int  out  1  interrupt request to CPU
- vec  out  8  interrupt vector
- vec_oe  out  1  vector valid/drive enable for the data bus buffer
- stat  out  8  IRR or ISR per ocw3_ris (registered)

## Operation
- Reset state: IRR, ISR and prio_base are 0. FSM is IDLE. int, vec, vec_oe and stat are 0.
- Edge mode: an IRR bit sets on a synchronized 0→1 transition of its `ir` line. It clears if that line returns low before the first INTA.
- Level mode: the IRR bit follows the synchronized line.
- Priority: the order is circular, starting at prio_base (highest) and wrapping 7→0. The resolver selects the first set bit of (IRR & ~IMR) in that order.
- Fully nested: int=1 only when a candidate exists and either ISR=0 or the candidate ranks above the highest-priority ISR bit.
- FSM IDLE → ACK1 on an intan falling edge:
  - Freeze the selected level `lvl`, set ISR[lvl], clear IRR[lvl], and drop int.
  - If there is no candidate at that edge (spurious), use lvl=7 and leave ISR unchanged.
- ACK1 → ACK2 on the second intan falling edge. Drive vec={icw2_vec,lvl} with vec_oe=1.
- ACK2 → IDLE on the intan rising edge. vec_oe drops. If icw4_aeoi=1 and the request was not spurious, clear ISR[lvl].
- OCW2 commands, decoded from ocw2[7:5] on ocw2_wr:
  - 001: non-specific EOI; clear the highest-priority ISR bit.
  - 011: specific EOI; clear ISR[L].
  - 101: rotate on non-specific EOI; clear the highest ISR bit n and set prio_base=n+1 mod 8.
  - 111: rotate on specific EOI; clear ISR[L] and set prio_base=L+1 mod 8.
  - 110: set priority; prio_base=L+1 mod 8.
  - All other codes: no-op.
  - A non-specific EOI with ISR=0 is a no-op and prio_base is unchanged.
- Simultaneous events:
  - When an EOI and the ISR set from INTA land in the same cycle, the EOI evaluates the pre-update ISR, and the set wins on the same bit.
  - An IRR set and an IRR clear from INTA on the same bit in the same cycle resolve to the clear.
- Reset asserted mid-sequence immediately returns every register to its reset value. vec_oe drops asynchronously.

## Timing
- `ir` 0→1 with IMR clear and ISR empty: IRR sets SYNC_STAGES+1 edges later, and int=1 one edge after that.
- Mask changes and OCW2 effects become visible on int one cycle after the update.
- intan edge detect compares intan against its one-cycle delayed copy. Actions take effect at the clock edge that detects the edge.
- vec and vec_oe are registered: valid from the edge after the second fall is detected until the edge after the rise is detected.
- Each INTA low and high phase must be at least 2 clk cycles.
- stat is updated every cycle with one-cycle latency.

## Structure
- Shared package `pic_pkg`:
  - OCW2 command constants.
  - FSM state enum (IDLE, ACK1, ACK2).
  - Function returning the highest set bit above prio_base of an 8-bit mask (used for ISR).
- Sub-module `pic_prio_resolver`: combinational rotating find-first with inputs (mask, prio_base) and outputs (valid, lvl). It is instantiated once for candidates and once for ISR.

## Test plan
- icw2_vec=5'b01000, IMR=0, pulse ir[3]: int rises SYNC_STAGES+2 cycles later. Two INTA pulses give vec=8'h43 with vec_oe, ISR=8'h08, and int low. Then ocw2=8'h20 gives ISR=8'h00.
- ocw1_imr=8'h08 and ir[3] high: int stays 0. Set IMR=8'h00 and int rises one cycle later.
- ISR=8'h20 (IR5 in service): raising ir[6] leaves int=0, and raising ir[2] sets int=1. INTA gives vec level 2 and ISR=8'h24.
- ISR=8'h10, write ocw2=8'hA0: ISR=0 and prio_base=5. Then ir[0] and ir[5] rise together and INTA gives level 5.
- Edge mode: pulse ir[1] and drop it before the first INTA. INTA gives vec={icw2_vec,3'd7} and ISR stays 8'h00.
- icw4_aeoi=1 with ir[4]: ISR[4] clears on the final intan rise. Asserting rstn=0 between the two INTA pulses clears all state, sets int=0 and vec_oe=0, and the FSM ends in IDLE.
